fpu_addsub_seq: RTL
===================

Name: fpu_addsub_seq

Overview:
- Multi-cycle sequencer in front of the single-precision add/sub datapath (align → add → normalize/round).
- Accepts one FP add/sub request over a valid/ready handshake and resolves the rounding mode (static or dynamic from fcsr).
- Registers the operands, drives per-stage enables to the datapath, captures the rounded result and flags, and returns them over a valid/ready response port.
- Sits between the FP issue logic and the add/sub datapath.

Parameters:
- ADD_CYCLES, 1: cycles spent in ADD state (1..4); the datapath adder is multicycle when >1.
- CNT_W, 2: width of the ADD cycle counter; must satisfy 2^CNT_W >= ADD_CYCLES.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- flush  in  1  abort in-flight op (pipeline flush).
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid&req_ready.
- req_sub  in  1  1=subtract (fp1-fp2), 0=add.
- req_fp1  in  32  operand 1 (IEEE-754 single).
- req_fp2  in  32  operand 2.
- req_rm  in  3  instruction rm field; 3'b111=DYN.
- fcsr_frm  in  3  fcsr.frm, sampled at accept.
- dp_fp1  out  32  registered operand 1 to datapath.
- dp_fp2  out  32  registered operand 2; sign bit inverted when req_sub.
- dp_frm  out  3  resolved rounding mode.
- dp_align_en  out  1  align-stage enable.
- dp_add_en  out  1  add-stage enable.
- dp_round_en  out  1  normalize/round-stage enable.
- dp_result  in  32  datapath result, valid in ROUND cycle.
- dp_flags  in  5  {NV,DZ,OF,UF,NX}, valid in ROUND cycle.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer ready.
- rsp_result  out  32  captured result.
- rsp_flags  out  5  captured flags.
- rsp_illegal  out  1  resolved rm was illegal; result/flags are 0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, nRST low): state=IDLE, counter=0, all out registers 0. req_ready=1 once nRST deasserts. rsp_valid=0, all dp_*_en=0, busy=0.
- rm resolution at accept: rm = (req_rm==3'b111) ? fcsr_frm : req_rm. Resolved 101/110/111 → illegal.
- States: IDLE, ALIGN, ADD, ROUND, RESP.
- IDLE: req_ready=1.
  - Accept with legal rm → register operands and rm → ALIGN.
  - Accept with illegal rm → RESP with rsp_illegal=1, result=0, flags=0; no dp enables pulse.
- ALIGN: dp_align_en=1 for exactly 1 cycle → ADD, counter=0.
- ADD: dp_add_en=1 every cycle. Counter increments; leave to ROUND after ADD_CYCLES cycles (counter==ADD_CYCLES-1).
- ROUND: dp_round_en=1 for 1 cycle. dp_result/dp_flags captured at the end of this cycle → RESP.
- RESP: rsp_valid=1; result/flags/illegal held stable until rsp_ready.
  - rsp_ready=1 → handshake completes. req_ready=rsp_ready in RESP, so a new request accepted in the same cycle goes directly to ALIGN (or RESP if illegal). Otherwise → IDLE.
  - rsp_ready=0 → hold; req_ready=0.
- Latency, legal op, rsp_ready=1: accept edge T → ALIGN T+1, ADD T+2..T+1+ADD_CYCLES, ROUND next, rsp_valid the following cycle. Default: rsp_valid at T+4. Throughput is 1 op per 3+ADD_CYCLES cycles with back-to-back accept.
- Illegal rm: rsp_valid at T+1.
- dp_fp1/dp_fp2/dp_frm hold from accept until the next accept; never change mid-operation.
- flush:
  - Synchronous; highest priority in every state. → IDLE next cycle; rsp_valid drops; in-flight result discarded; dp enables 0 next cycle.
  - flush with req_valid in the same cycle: request is not accepted (req_ready forced 0).
  - flush in RESP with rsp_ready=1: the handshake counts as completed (consumer took it), state → IDLE.
- req_valid while busy (not RESP): ignored, req_ready=0.
- nRST asserted mid-operation: immediate return to reset values; no response produced.

Decomposition:
- Package fpu_types_pkg:
  - rm_t localparams/enum RNE=000, RZE=001, RDN=010, RUP=011, RMM=100, DYN=111.
  - seq_state_t enum {IDLE, ALIGN, ADD, ROUND, RESP}.
  - fflags_t packed struct {nv,dz,of,uf,nx}.
- Sub-module fpu_rm_resolve (combinational): req_rm + fcsr_frm → resolved rm + illegal. Shared with the mul/div sequencers.

Test Plan:
- Bench dp model returns 0x40000000, flags 0. Stimulus: req 0x3F800000+0x3F800000, req_rm=000, rsp_ready=1 → align/add/round enables each pulse once at T+1/T+2/T+3; rsp_valid at T+4 with result 0x40000000, flags 0, illegal 0.
- req_sub=1, fp2=0x3F800000 → dp_fp2=0xBF800000. req_rm=111 with fcsr_frm=010 → dp_frm=010.
- req_rm=111 with fcsr_frm=101 → no dp enables; rsp_valid at T+1, rsp_illegal=1, result 0.
- rsp_ready=0 for 5 cycles in RESP → result stable, req_ready=0. Then rsp_ready=1 with req_valid=1 → new op accepted that cycle, ALIGN next cycle.
- flush asserted during ADD → IDLE next cycle, no rsp_valid. With ADD_CYCLES=3: dp_add_en high exactly 3 cycles, rsp_valid at T+6.
- nRST pulsed low in ROUND → all outputs 0 immediately, busy=0; next request completes normally.

Source files
------------

// File: rtl/fpu_types_pkg.sv
// Shared FP sequencer types: rounding-mode encodings, sequencer states and
// the accrued-exception flag layout used by the add/sub, mul and div paths.
package fpu_types_pkg;

   typedef logic [2:0] rm_t;

   localparam rm_t RNE = 3'b000;
   localparam rm_t RZE = 3'b001;
   localparam rm_t RDN = 3'b010;
   localparam rm_t RUP = 3'b011;
   localparam rm_t RMM = 3'b100;
   localparam rm_t DYN = 3'b111;

   // Explicit encodings keep state values identical to the legacy 3-bit codes.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ALIGN = 3'd1,
      ADD   = 3'd2,
      ROUND = 3'd3,
      RESP  = 3'd4
   } seq_state_t;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fflags_t;

endpackage

// File: rtl/fpu_rm_resolve.sv
// Resolves the effective rounding mode from the instruction rm field and
// fcsr.frm; flags reserved encodings as illegal.
module fpu_rm_resolve
   import fpu_types_pkg::*;
(
   input  logic [2:0] req_rm,
   input  logic [2:0] fcsr_frm,
   output logic [2:0] rm,
   output logic       illegal
);

   always_comb begin
      rm = (req_rm == DYN) ? fcsr_frm : req_rm;
      case (rm)
         RNE, RZE, RDN, RUP, RMM: illegal = 1'b0;
         default:                 illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle sequencer in front of the single-precision add/sub datapath:
// accepts a request, steps align/add/round enables, returns result and flags.
module fpu_addsub_seq
   import fpu_types_pkg::*;
#(
   parameter int ADD_CYCLES = 1,
   parameter int CNT_W      = 2
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_sub,
   input  logic [31:0] req_fp1,
   input  logic [31:0] req_fp2,
   input  logic [2:0]  req_rm,
   input  logic [2:0]  fcsr_frm,
   output logic [31:0] dp_fp1,
   output logic [31:0] dp_fp2,
   output logic [2:0]  dp_frm,
   output logic        dp_align_en,
   output logic        dp_add_en,
   output logic        dp_round_en,
   input  logic [31:0] dp_result,
   input  logic [4:0]  dp_flags,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic [4:0]  rsp_flags,
   output logic        rsp_illegal,
   output logic        busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADD_CYCLES - 1);

   seq_state_t       state_q;
   seq_state_t       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       rm_res;
   logic             rm_ill;
   logic             accept;
   logic [31:0]      fp1_q;
   logic [31:0]      fp2_q;
   logic [2:0]       frm_q;
   logic [31:0]      result_q;
   fflags_t          flags_q;
   logic             illegal_q;

   fpu_rm_resolve u_rm_resolve (
      .req_rm   (req_rm),
      .fcsr_frm (fcsr_frm),
      .rm       (rm_res),
      .illegal  (rm_ill)
   );

   // A new request may land in the same cycle the current response is taken.
   always_comb begin
      req_ready = 1'b0;
      if (nRST && !flush) begin
         case (state_q)
            IDLE:    req_ready = 1'b1;
            RESP:    req_ready = rsp_ready;
            default: req_ready = 1'b0;
         endcase
      end
   end

   assign accept = req_valid & req_ready;

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) state_d = rm_ill ? RESP : ALIGN;
            end
            ALIGN: state_d = ADD;
            ADD: begin
               if (cnt_q == CNT_LAST) state_d = ROUND;
            end
            ROUND: state_d = RESP;
            RESP: begin
               if (rsp_ready) begin
                  if (accept) state_d = rm_ill ? RESP : ALIGN;
                  else        state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         fp1_q     <= '0;
         fp2_q     <= '0;
         frm_q     <= '0;
         result_q  <= '0;
         flags_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;

         if (state_q == ADD && !flush) cnt_q <= cnt_q + CNT_W'(1);
         else                          cnt_q <= '0;

         // Operands stay frozen from one legal accept to the next.
         if (accept && !rm_ill) begin
            fp1_q <= req_fp1;
            fp2_q <= {req_fp2[31] ^ req_sub, req_fp2[30:0]};
            frm_q <= rm_res;
         end

         if (accept && rm_ill) begin
            result_q  <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b1;
         end else if (state_q == ROUND && !flush) begin
            result_q  <= dp_result;
            flags_q   <= fflags_t'(dp_flags);
            illegal_q <= 1'b0;
         end
      end
   end

   assign dp_fp1      = fp1_q;
   assign dp_fp2      = fp2_q;
   assign dp_frm      = frm_q;
   assign dp_align_en = (state_q == ALIGN);
   assign dp_add_en   = (state_q == ADD);
   assign dp_round_en = (state_q == ROUND);
   assign rsp_valid   = (state_q == RESP);
   assign rsp_result  = result_q;
   assign rsp_flags   = flags_q;
   assign rsp_illegal = illegal_q;
   assign busy        = (state_q != IDLE);

endmodule
